cpu_run_ctrl: RTL and testbench

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_run_ctrl_pkg.sv | 22 ++
 rtl/cpu_run_ctrl_edge_sync.sv | 47 ++++
 rtl/cpu_run_ctrl.sv | 123 ++++++++++++
 tb/tb_cpu_run_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the CPU run controller: FSM state encoding, LED source
// select codes and the clock-enable decode used by the top level.
package cpu_run_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2,
      HALT = 2'd3
   } run_state_e;

   localparam logic [1:0] SEL_DISP  = 2'b00;
   localparam logic [1:0] SEL_CYCLE = 2'b01;
   localparam logic [1:0] SEL_JMP   = 2'b10;
   localparam logic [1:0] SEL_BR    = 2'b11;

   // The pipeline advances only in the two executing states.
   function automatic logic state_is_exec(input run_state_e s);
      return (s == RUN) || (s == STEP);
   endfunction

endpackage

// File: rtl/cpu_run_ctrl_edge_sync.sv
// Synchronizer plus registered rising-edge detector for an asynchronous
// level input. The pulse appears SYNC_STAGES+1 clocks after the input
// rises. A level that is already high when reset releases is not an edge:
// the detector only arms after it has seen the synchronized input low.
module edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic pulse_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   primed_q;
   logic                   armed_q;
   logic                   pulse_q;

   // Synchronizer chain, arming logic and edge-detect register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q   <= '0;
         prev_q   <= 1'b0;
         primed_q <= 1'b0;
         armed_q  <= 1'b0;
         pulse_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every flop here sample the
         // pre-edge value, so the chain shifts exactly one stage per clock.
         sync_q[0] <= async_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q   <= sync_q[SYNC_STAGES-1];
         // First stage holds a real sample only after one clock out of reset.
         primed_q <= 1'b1;
         if (primed_q && !sync_q[0]) begin
            armed_q <= 1'b1;
         end
         pulse_q  <= armed_q & sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run/step/halt controller with LED readout.
// Optional statistics counters (cycles, jumps, taken branches) are built
// only when RUN_CTRL_STATS_EN is defined; otherwise the counter selects
// read as zero.
module cpu_run_ctrl
   import cpu_run_ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic             step_mode,
   input  logic             halt_req,
   input  logic             is_jmp,
   input  logic             br_taken,
   input  logic [CNT_W-1:0] disp_data,
   input  logic [1:0]       select,
   output logic             cpu_en,
   output logic             halted,
   output logic [CNT_W-1:0] led_data
);

   logic             go_pulse;
   run_state_e       state_q, state_d;
   logic [CNT_W-1:0] led_data_d, led_data_q;

   edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_go_sync (
      .clk    (clk),
      .rst    (rst),
      .async_i(go),
      .pulse_o(go_pulse)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; halt requests win over a step-mode pause.
   always_comb begin
      // NOTE: assigning the default first keeps this block free of latches.
      state_d = state_q;
      case (state_q)
         IDLE: if (go_pulse) state_d = step_mode ? STEP : RUN;
         RUN: begin
            if (halt_req)       state_d = HALT;
            else if (step_mode) state_d = IDLE;
         end
         STEP: state_d = halt_req ? HALT : IDLE;
         HALT: if (go_pulse) state_d = step_mode ? STEP : RUN;
         default: state_d = IDLE;
      endcase
   end

   // Moore output decode from the state register only.
   always_comb begin
      cpu_en = state_is_exec(state_q);
      halted = (state_q == HALT);
   end

`ifdef RUN_CTRL_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cycle_cnt_q, jmp_cnt_q, br_cnt_q;

   // Saturating statistics counters, cleared only by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_cnt_q <= '0;
         jmp_cnt_q   <= '0;
         br_cnt_q    <= '0;
      end else if (cpu_en) begin
         if (cycle_cnt_q != CNT_MAX)           cycle_cnt_q <= cycle_cnt_q + 1'b1;
         if (is_jmp && jmp_cnt_q != CNT_MAX)   jmp_cnt_q   <= jmp_cnt_q + 1'b1;
         if (br_taken && br_cnt_q != CNT_MAX)  br_cnt_q    <= br_cnt_q + 1'b1;
      end
   end

   // LED source select across display word and counters.
   always_comb begin
      led_data_d = '0;
      case (select)
         SEL_DISP:  led_data_d = disp_data;
         SEL_CYCLE: led_data_d = cycle_cnt_q;
         SEL_JMP:   led_data_d = jmp_cnt_q;
         SEL_BR:    led_data_d = br_cnt_q;
         default:   led_data_d = '0;
      endcase
   end
`else
   // Retire-event inputs have no consumer without the counters.
   logic unused_stats_in;
   assign unused_stats_in = is_jmp ^ br_taken;

   // LED source select: only the display word exists in this build.
   always_comb begin
      led_data_d = '0;
      if (select == SEL_DISP) begin
         led_data_d = disp_data;
      end
   end
`endif

   // LED output register gives the one-clock readout latency.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led_data_q <= '0;
      end else begin
         led_data_q <= led_data_d;
      end
   end

   assign led_data = led_data_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl. Two instances share all stimulus: a 32-bit one
// and a 4-bit one whose counters reach saturation quickly. LED expectations
// go into a scoreboard when the select/display inputs are driven and are
// compared on the falling edge after the clock that registers them.
module tb_cpu_run_ctrl;
   import cpu_run_ctrl_pkg::*;

`ifdef RUN_CTRL_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, go, step_mode, halt_req, is_jmp, br_taken;
   logic [31:0] disp_data;
   logic [1:0]  select;
   logic        cpu_en, halted, cpu_en4, halted4;
   logic [31:0] led_data;
   logic [3:0]  led4;

   int          n_tests = 0;
   int          n_fail  = 0;
   int unsigned cyc     = 0;
   int unsigned m_cyc, m_jmp, m_br;

   typedef struct {
      int unsigned due;
      logic [31:0] exp32;
      logic [3:0]  exp4;
   } sb_t;
   sb_t sb_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cpu_run_ctrl #(.CNT_W(32), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .go(go), .step_mode(step_mode), .halt_req(halt_req),
      .is_jmp(is_jmp), .br_taken(br_taken), .disp_data(disp_data), .select(select),
      .cpu_en(cpu_en), .halted(halted), .led_data(led_data)
   );

   cpu_run_ctrl #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
      .clk(clk), .rst(rst), .go(go), .step_mode(step_mode), .halt_req(halt_req),
      .is_jmp(is_jmp), .br_taken(br_taken), .disp_data(disp_data[3:0]), .select(select),
      .cpu_en(cpu_en4), .halted(halted4), .led_data(led4)
   );

   function automatic logic [31:0] cnt32(input int unsigned v);
      return STATS ? v : 32'd0;
   endfunction

   function automatic logic [3:0] cnt4(input int unsigned v);
      return STATS ? ((v > 15) ? 4'd15 : v[3:0]) : 4'd0;
   endfunction

   // One clock; the model counters advance when the bench expects cpu_en=1.
   task automatic tick(input bit en);
      @(posedge clk);
      #1;
      if (en) begin
         m_cyc++;
         if (is_jmp)   m_jmp++;
         if (br_taken) m_br++;
      end
   endtask

   // Record what led_data must show after the next rising edge.
   task automatic push_sel();
      sb_t e;
      e.due = cyc + 1;
      case (select)
         SEL_DISP:  begin e.exp32 = disp_data;     e.exp4 = disp_data[3:0]; end
         SEL_CYCLE: begin e.exp32 = cnt32(m_cyc);  e.exp4 = cnt4(m_cyc);    end
         SEL_JMP:   begin e.exp32 = cnt32(m_jmp);  e.exp4 = cnt4(m_jmp);    end
         default:   begin e.exp32 = cnt32(m_br);   e.exp4 = cnt4(m_br);     end
      endcase
      sb_q.push_back(e);
   endtask

   // Scoreboard consumer.
   always @(negedge clk) begin
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
         sb_t e;
         e = sb_q.pop_front();
         n_tests++;
         if (led_data !== e.exp32) begin
            n_fail++;
            $display("FAIL led_data32 cyc=%0d: got %h want %h", cyc, led_data, e.exp32);
         end
         n_tests++;
         if (led4 !== e.exp4) begin
            n_fail++;
            $display("FAIL led_data4 cyc=%0d: got %h want %h", cyc, led4, e.exp4);
         end
      end
   end

   task automatic do_reset();
      rst = 1'b0;
      go  = 1'b0;
      repeat (3) tick(0);
      m_cyc = 0; m_jmp = 0; m_br = 0;
      rst = 1'b1;
      repeat (3) tick(0);
   endtask

   task automatic test_reset();
      rst = 1'b0; go = 1'b0; step_mode = 1'b0; halt_req = 1'b0;
      is_jmp = 1'b0; br_taken = 1'b0; select = SEL_DISP; disp_data = 32'hA5A5_5A5A;
      m_cyc = 0; m_jmp = 0; m_br = 0;
      repeat (3) tick(0);
      n_tests++;
      if ({cpu_en, cpu_en4} !== 2'b00) begin
         n_fail++; $display("FAIL reset cpu_en: got %b want 00", {cpu_en, cpu_en4});
      end
      n_tests++;
      if ({halted, halted4} !== 2'b00) begin
         n_fail++; $display("FAIL reset halted: got %b want 00", {halted, halted4});
      end
      n_tests++;
      if (led_data !== 32'd0 || led4 !== 4'd0) begin
         n_fail++; $display("FAIL reset led: got %h/%h want 0/0", led_data, led4);
      end
      rst = 1'b1;
      repeat (3) tick(0);
      n_tests++;
      if ({cpu_en, halted} !== 2'b00) begin
         n_fail++; $display("FAIL reset release idle: got %b want 00", {cpu_en, halted});
      end
      push_sel();
      tick(0);
   endtask

   task automatic test_run_start();
      step_mode = 1'b0;
      go = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         logic exp;
         exp = (c >= 4);
         tick(c >= 5);
         if (c == 5) go = 1'b0;
         n_tests++;
         if ({cpu_en, cpu_en4} !== {exp, exp} || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL run_start c=%0d: got en=%b%b halt=%b want en=%b halt=0",
                     c, cpu_en, cpu_en4, halted, exp);
         end
      end
   endtask

   task automatic test_halt();
      select = SEL_CYCLE;
      push_sel();
      halt_req = 1'b1;
      n_tests++;
      if (cpu_en !== 1'b1) begin
         n_fail++; $display("FAIL halt cycle cpu_en: got %b want 1", cpu_en);
      end
      tick(1);
      halt_req = 1'b0;
      n_tests++;
      if ({cpu_en, halted, halted4} !== 3'b011) begin
         n_fail++; $display("FAIL halt entry: got %b want 011", {cpu_en, halted, halted4});
      end
      for (int c = 1; c <= 4; c++) begin
         push_sel();
         tick(0);
         n_tests++;
         if ({cpu_en, halted} !== 2'b01) begin
            n_fail++; $display("FAIL halt hold c=%0d: got %b want 01", c, {cpu_en, halted});
         end
      end
      go = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         logic [1:0] exp;
         exp = {(c >= 4) ? 1'b1 : 1'b0, (c < 4) ? 1'b1 : 1'b0};
         push_sel();
         tick(c >= 5);
         if (c == 2) go = 1'b0;
         n_tests++;
         if ({cpu_en, halted} !== exp) begin
            n_fail++; $display("FAIL halt resume c=%0d: got %b want %b", c, {cpu_en, halted}, exp);
         end
      end
      step_mode = 1'b1;
      push_sel();
      tick(1);
      n_tests++;
      if ({cpu_en, halted} !== 2'b00) begin
         n_fail++; $display("FAIL pause: got %b want 00", {cpu_en, halted});
      end
      push_sel();
      tick(0);
   endtask

   task automatic test_step();
      do_reset();
      step_mode = 1'b1;
      for (int p = 0; p < 3; p++) begin
         go = 1'b1;
         for (int c = 1; c <= 8; c++) begin
            tick(c == 5);
            if (c == 2) go = 1'b0;
            n_tests++;
            if (cpu_en !== (c == 4) || halted !== 1'b0) begin
               n_fail++;
               $display("FAIL step p=%0d c=%0d: got en=%b halt=%b want en=%b halt=0",
                        p, c, cpu_en, halted, (c == 4));
            end
         end
      end
      select = SEL_CYCLE;
      push_sel();
      tick(0);
      push_sel();
      tick(0);
      // A halt decoded during a single step parks the controller in HALT.
      halt_req = 1'b1;
      go = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick(c == 5);
         if (c == 2) go = 1'b0;
         if (c == 5) halt_req = 1'b0;
         n_tests++;
         if (cpu_en !== (c == 4) || halted !== (c >= 5)) begin
            n_fail++;
            $display("FAIL step_halt c=%0d: got en=%b halt=%b want en=%b halt=%b",
                     c, cpu_en, halted, (c == 4), (c >= 5));
         end
      end
      go = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick(c == 5);
         if (c == 2) go = 1'b0;
         n_tests++;
         if (cpu_en !== (c == 4) || halted !== (c < 4)) begin
            n_fail++;
            $display("FAIL halt_to_step c=%0d: got en=%b halt=%b want en=%b halt=%b",
                     c, cpu_en, halted, (c == 4), (c < 4));
         end
      end
      push_sel();
      tick(0);
   endtask

   task automatic test_jmp_br();
      step_mode = 1'b0;
      is_jmp    = 1'b1;
      br_taken  = 1'b1;
      repeat (4) begin
         tick(0);
         n_tests++;
         if (cpu_en !== 1'b0) begin
            n_fail++; $display("FAIL jmp_br idle cpu_en: got %b want 0", cpu_en);
         end
      end
      go = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick(c >= 5);
         if (c == 2) go = 1'b0;
         if (c == 8) begin is_jmp = 1'b0; br_taken = 1'b0; end
         n_tests++;
         if (cpu_en !== (c >= 4)) begin
            n_fail++; $display("FAIL jmp_br run c=%0d: got %b want %b", c, cpu_en, (c >= 4));
         end
      end
      step_mode = 1'b1;
      tick(1);
      select = SEL_JMP;   push_sel(); tick(0);
      select = SEL_BR;    push_sel(); tick(0);
      select = SEL_CYCLE; push_sel(); tick(0);
   endtask

   task automatic test_saturate_and_reset();
      step_mode = 1'b0;
      select    = SEL_CYCLE;
      go        = 1'b1;
      for (int c = 1; c <= 24; c++) begin
         push_sel();
         tick(c >= 5);
         if (c == 2) go = 1'b0;
         n_tests++;
         if ({cpu_en, cpu_en4} !== {2{c >= 4}}) begin
            n_fail++; $display("FAIL sat run c=%0d: got %b want %b", c, cpu_en, (c >= 4));
         end
      end
      tick(1);
      // Asynchronous reset in the middle of a RUN cycle with go held high.
      go = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      n_tests++;
      if ({cpu_en, cpu_en4, halted} !== 3'b000) begin
         n_fail++; $display("FAIL async reset: got %b want 000", {cpu_en, cpu_en4, halted});
      end
      n_tests++;
      if (led_data !== 32'd0 || led4 !== 4'd0) begin
         n_fail++; $display("FAIL async reset led: got %h/%h want 0/0", led_data, led4);
      end
      m_cyc = 0; m_jmp = 0; m_br = 0;
      repeat (2) tick(0);
      rst = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         push_sel();
         tick(0);
         n_tests++;
         if ({cpu_en, halted} !== 2'b00) begin
            n_fail++; $display("FAIL no restart c=%0d: got %b want 00", c, {cpu_en, halted});
         end
      end
      go = 1'b0;
      repeat (4) tick(0);
      go = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick(c >= 5);
         if (c == 2) go = 1'b0;
         n_tests++;
         if (cpu_en !== (c >= 4)) begin
            n_fail++; $display("FAIL rearm c=%0d: got %b want %b", c, cpu_en, (c >= 4));
         end
      end
      step_mode = 1'b1;
      tick(1);
   endtask

   task automatic test_disp();
      select    = SEL_DISP;
      disp_data = 32'hDEAD_BEEF; push_sel(); tick(0);
      disp_data = 32'h0123_4567; push_sel(); tick(0);
      disp_data = 32'h0000_0000; push_sel(); tick(0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      test_reset();
      test_run_start();
      test_halt();
      test_step();
      test_jmp_br();
      test_saturate_and_reset();
      test_disp();
      repeat (2) tick(0);
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++; $display("FAIL scoreboard drain: got %0d left want 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
